button_debounce_edge: RTL and testbench
=======================================

Name: button_debounce_edge

Overview:
- Conditions one raw push-button or switch input for the board-level datapath.
- Synchronizes the input into the `clk` domain and filters contact bounce with a stability counter.
- Produces a clean level, one-cycle press/release pulses and a wrapping press counter.
- Sits directly upstream of the registered-flop stages that capture user inputs; its pulses act as their enables.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on `btn_raw`; legal range 2..4.
- DEBOUNCE_CYCLES, 500000, consecutive stable samples needed to accept a new level (5 ms at 100 MHz); legal range ≥ 2.
- CNT_W, 20, stability counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- btn_raw  input  1  raw, asynchronous, bouncing button level.
- btn_level  output  1  debounced level; registered.
- btn_press  output  1  one-cycle pulse on an accepted 0→1 transition.
- btn_release  output  1  one-cycle pulse on an accepted 1→0 transition.
- press_cnt  output  8  count of accepted presses; wraps 255→0.

Behaviour:
- Reset (reset=0, asynchronous):
  - all synchronizer flops = 0, state = IDLE_LOW, cnt = 0.
  - btn_level = 0, btn_press = 0, btn_release = 0, press_cnt = 0.
  - Reset applied mid-operation discards any partial count.
- Synchronizer: SYNC_STAGES-deep shift chain; `sync` is the last stage. No logic between stages.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW. Encoding is free.
  - IDLE_LOW: sync=1 → WAIT_HIGH, cnt<=1; else stay, cnt<=0.
  - WAIT_HIGH:
    - sync=0 → IDLE_LOW, cnt<=0 (glitch rejected, no pulse).
    - sync=1 and cnt==DEBOUNCE_CYCLES-1 → IDLE_HIGH; btn_level<=1, btn_press<=1, press_cnt<=press_cnt+1; cnt<=0.
    - otherwise cnt<=cnt+1.
  - IDLE_HIGH / WAIT_LOW: mirror image with sync=0 as the candidate level; acceptance sets btn_level<=0, btn_release<=1; press_cnt unchanged.
- Acceptance rule: a new level is accepted after DEBOUNCE_CYCLES consecutive identical sync samples.
- Pulses:
  - btn_press and btn_release are high for exactly one clk cycle and are never high together.
  - Both default to 0 every cycle unless set by an acceptance transition.
- Latency: btn_raw stable from before edge 1 → btn_level/pulse update after edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Width rules:
  - cnt never exceeds DEBOUNCE_CYCLES-1 and does not saturate.
  - press_cnt is modulo-256 unsigned.
- Button held through reset: after reset deasserts the input is treated as a new press and reported with the normal latency.
- Outputs are glitch-free registers; none is a combinational path from btn_raw.

Test Plan:
- SYNC_STAGES=2, DEBOUNCE_CYCLES=4; reset=0 for 3 cycles, btn_raw=1 throughout → all outputs 0 during reset. Release reset → btn_press=1 for exactly one cycle after edge 6, btn_level=1 thereafter, press_cnt=1.
- From IDLE_LOW, btn_raw high for 3 cycles then low → btn_level stays 0, no pulses, press_cnt unchanged.
- Bounce train: btn_raw toggles every 2 cycles for 20 cycles, then holds 1 → exactly one btn_press, 6 edges after the final rising transition; press_cnt +1.
- From IDLE_HIGH, btn_raw=0 stable → btn_release single-cycle pulse after edge 6, btn_level=0, press_cnt unchanged.
- Assert reset during WAIT_HIGH (cnt=2) → outputs 0 immediately (asynchronous). After release with btn_raw=0 → no pulse ever.
- 256 clean press/release cycles → press_cnt goes 255→0 on the 256th press; btn_press still pulses once per press.

Source files
------------

// File: rtl/button_debounce_edge.sv
// Push-button conditioner: synchronizer, bounce filter, edge pulses and
// a wrapping press counter, all registered in the clk domain.
module button_debounce_edge #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       btn_press,
    output logic       btn_release,
    output logic [7:0] press_cnt
);

    typedef enum logic [1:0] {
        IDLE_LOW,
        WAIT_HIGH,
        IDLE_HIGH,
        WAIT_LOW
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic [7:0]             r_press_cnt;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
        end
    end

    // The counter holds the number of consecutive candidate samples seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE_LOW;
            r_cnt       <= '0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_press_cnt <= 8'd0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            unique case (r_state)
                IDLE_LOW: begin
                    if (w_sync) begin
                        r_state <= WAIT_HIGH;
                        r_cnt   <= LP_ONE;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!w_sync) begin
                        r_state <= IDLE_LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == LP_LAST) begin
                        r_state     <= IDLE_HIGH;
                        r_level     <= 1'b1;
                        r_press     <= 1'b1;
                        r_press_cnt <= r_press_cnt + 8'd1;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + LP_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!w_sync) begin
                        r_state <= WAIT_LOW;
                        r_cnt   <= LP_ONE;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (w_sync) begin
                        r_state <= IDLE_HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt == LP_LAST) begin
                        r_state   <= IDLE_LOW;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + LP_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE_LOW;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign press_cnt   = r_press_cnt;

endmodule

// File: tb/tb_button_debounce_edge.sv
// Scoreboard bench: stimulus queues expected pulses, a negedge monitor
// pops and compares each pulse the debouncer emits.
module tb_button_debounce_edge;

    localparam int LAT = 6;

    logic       clk;
    logic       reset;
    logic       btn_raw;
    logic       btn_level;
    logic       btn_press;
    logic       btn_release;
    logic [7:0] press_cnt;

    typedef struct {
        int         edge_n;
        bit         is_press;
        logic [7:0] cnt;
        logic       lvl;
    } exp_t;

    exp_t q[$];
    int   edges  = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    button_debounce_edge #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .press_cnt  (press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic push(input bit is_press, input logic [7:0] cnt);
        exp_t e;
        e.edge_n   = edges + LAT;
        e.is_press = is_press;
        e.cnt      = cnt;
        e.lvl      = is_press;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every pulse must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (reset && (btn_press || btn_release)) begin
            chk("press_and_release", int'(btn_press & btn_release), 0);
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: press=%0b release=%0b at edge %0d, expected none",
                         btn_press, btn_release, edges);
            end else begin
                e = q.pop_front();
                chk("pulse_edge", edges, e.edge_n);
                chk("pulse_kind_press", int'(btn_press), int'(e.is_press));
                chk("pulse_press_cnt", int'(press_cnt), int'(e.cnt));
                chk("pulse_level", int'(btn_level), int'(e.lvl));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        btn_raw = 1'b1;
        // Button held through reset: outputs stay cleared.
        repeat (3) begin
            @(negedge clk);
            chk("rst_level", int'(btn_level), 0);
            chk("rst_press", int'(btn_press), 0);
            chk("rst_release", int'(btn_release), 0);
            chk("rst_press_cnt", int'(press_cnt), 0);
        end
        reset = 1'b1;
        push(1'b1, 8'd1);
        wait_cyc(10);
        chk("held_level", int'(btn_level), 1);

        btn_raw = 1'b0;
        push(1'b0, 8'd1);
        wait_cyc(10);
        chk("released_level", int'(btn_level), 0);

        // Short high glitch, rejected.
        btn_raw = 1'b1;
        wait_cyc(3);
        btn_raw = 1'b0;
        wait_cyc(12);
        chk("glitch_level", int'(btn_level), 0);
        chk("glitch_press_cnt", int'(press_cnt), 1);

        // Bounce train then a solid press.
        for (int i = 0; i < 10; i++) begin
            btn_raw = ~btn_raw;
            wait_cyc(2);
        end
        btn_raw = 1'b1;
        push(1'b1, 8'd2);
        wait_cyc(10);
        chk("bounce_press_cnt", int'(press_cnt), 2);

        btn_raw = 1'b0;
        push(1'b0, 8'd2);
        wait_cyc(10);

        // Reset in WAIT_HIGH with cnt=2.
        btn_raw = 1'b1;
        wait_cyc(4);
        #2 reset = 1'b0;
        btn_raw = 1'b0;
        #1;
        chk("async_press_cnt", int'(press_cnt), 0);
        chk("async_level", int'(btn_level), 0);
        chk("async_press", int'(btn_press), 0);
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(20);
        chk("post_rst_level", int'(btn_level), 0);
        chk("post_rst_press_cnt", int'(press_cnt), 0);

        // 256 clean presses: counter wraps to 0 on the last.
        for (int i = 0; i < 256; i++) begin
            btn_raw = 1'b1;
            push(1'b1, 8'(i + 1));
            wait_cyc(8);
            btn_raw = 1'b0;
            push(1'b0, 8'(i + 1));
            wait_cyc(8);
        end
        chk("wrap_press_cnt", int'(press_cnt), 0);

        wait_cyc(10);
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
